// File: rtl/alu_pkg.sv
// Shared types and byte-lane helpers for the multi-byte ALU sequencer.
package alu_pkg;

  typedef enum logic [4:0] {
    CMD_ADD = 5'd0,
    CMD_SUB = 5'd1,
    CMD_AND = 5'd2,
    CMD_XOR = 5'd3,
    CMD_CMP = 5'd4,
    CMD_CEQ = 5'd5,
    CMD_LSL = 5'd6,
    CMD_LSR = 5'd7,
    CMD_MOV = 5'd8
  } alu_cmd_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_CMP = 3'd4,
    OP_CEQ = 3'd5,
    OP_LSL = 3'd6,
    OP_LSR = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned IDX_W = 2;

  // Lane offset is built by concatenation so the index math cannot wrap in 2 bits.
  function automatic logic [7:0] get_byte(input logic [31:0] v, input logic [IDX_W-1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] v, input logic [IDX_W-1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = v;
    r[{k, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Multi-byte request sequencer driving an 8-bit combinational ALU one lane per cycle,
// chaining carry/shift between lanes and returning a single registered response.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic [4:0]            alu_cmd,
  output logic [7:0]            alu_inA,
  output logic [7:0]            alu_inB,
  output logic                  alu_sc_i,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_o,
  input  logic                  alu_cnd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_cnd
);

  localparam int unsigned W = 8 * NBYTES;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  seq_op_e          op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [4:0]       cmd_q, cmd_d;
  logic [7:0]       ina_q, ina_d, inb_q, inb_d;
  logic             sci_q, sci_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_cnd_q, rsp_cnd_d;

  logic             issue, issue_sc, done_cmp, cmp_val, last_lane, is_logic;
  logic [4:0]       issue_cmd;
  logic [W-1:0]     src_a, src_b;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_cnd_d   = rsp_cnd_q;
    cmd_d       = '0;
    ina_d       = '0;
    inb_d       = '0;
    sci_d       = 1'b0;
    issue       = 1'b0;
    issue_cmd   = '0;
    issue_sc    = 1'b0;
    src_a       = a_q;
    src_b       = b_q;
    done_cmp    = 1'b0;
    cmp_val     = 1'b0;
    last_lane   = (op_q == OP_LSR) ? (idx_q == '0) : (idx_q == LAST);
    is_logic    = (op_q == OP_AND) || (op_q == OP_XOR);

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = seq_op_e'(req_op);
          a_d       = req_a;
          b_d       = req_b;
          res_d     = '0;
          phase_d   = 1'b0;
          idx_d     = (op_d inside {OP_LSR, OP_CMP, OP_CEQ}) ? LAST : '0;
          issue     = 1'b1;
          issue_cmd = (op_d inside {OP_CMP, OP_CEQ}) ? CMD_CEQ : {2'b00, req_op};
          src_a     = req_a;
          src_b     = req_b;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_CEQ: begin
            if (!alu_cnd || idx_q == '0) begin
              done_cmp = 1'b1;
              cmp_val  = alu_cnd;
            end else begin
              idx_d     = idx_q - 1'b1;
              issue     = 1'b1;
              issue_cmd = CMD_CEQ;
            end
          end
          OP_CMP: begin
            // First differing byte (high first) is re-issued as CMP to get the ordering.
            if (phase_q) begin
              done_cmp = 1'b1;
              cmp_val  = alu_cnd;
            end else if (!alu_cnd) begin
              phase_d   = 1'b1;
              issue     = 1'b1;
              issue_cmd = CMD_CMP;
            end else if (idx_q == '0) begin
              done_cmp = 1'b1;
            end else begin
              idx_d     = idx_q - 1'b1;
              issue     = 1'b1;
              issue_cmd = CMD_CEQ;
            end
          end
          default: begin
            res_d = W'(put_byte(32'(res_q), idx_q, alu_rslt));
            if (last_lane) begin
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
              rsp_data_d  = res_d;
              rsp_carry_d = is_logic ? 1'b0 : alu_sc_o;
              rsp_cnd_d   = 1'b0;
            end else begin
              idx_d     = (op_q == OP_LSR) ? idx_q - 1'b1 : idx_q + 1'b1;
              issue     = 1'b1;
              issue_cmd = {2'b00, op_q};
              issue_sc  = (op_q == OP_SUB) ? ~alu_sc_o : (is_logic ? 1'b0 : alu_sc_o);
            end
          end
        endcase
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done_cmp) begin
      state_d     = S_DONE;
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      rsp_carry_d = 1'b0;
      rsp_cnd_d   = cmp_val;
    end

    if (issue) begin
      cmd_d = issue_cmd;
      ina_d = get_byte(32'(src_a), idx_d);
      inb_d = get_byte(32'(src_b), idx_d);
      sci_d = issue_sc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      cmd_q       <= '0;
      ina_q       <= '0;
      inb_q       <= '0;
      sci_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_cnd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      cmd_q       <= cmd_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      sci_q       <= sci_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_cnd_q   <= rsp_cnd_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign alu_cmd   = cmd_q;
  assign alu_inA   = ina_q;
  assign alu_inB   = inb_q;
  assign alu_sc_i  = sci_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_cnd   = rsp_cnd_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural 8-bit ALU attached and a
// word-level reference model for responses and EXEC cycle counts.
module tb_alu_seq;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic [4:0]   alu_cmd;
  logic [7:0]   alu_inA, alu_inB, alu_rslt;
  logic         alu_sc_i, alu_sc_o, alu_cnd;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_carry, rsp_cnd;
  logic [8:0]   alu_tmp;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [4:0] tr_cmd [0:7];
  logic [7:0] tr_a   [0:7];
  logic [7:0] tr_b   [0:7];
  logic       tr_sc  [0:7];

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_cnd(alu_cnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_cnd(rsp_cnd)
  );

  // Combinational 8-bit ALU: sc_i is carry-in (ADD), borrow-in (SUB), shift-in (LSL/LSR).
  always_comb begin
    alu_tmp  = '0;
    alu_rslt = '0;
    alu_sc_o = 1'b0;
    alu_cnd  = 1'b0;
    case (alu_cmd)
      5'd0: begin
        alu_tmp  = {1'b0, alu_inA} + {1'b0, alu_inB} + 9'(alu_sc_i);
        alu_rslt = alu_tmp[7:0];
        alu_sc_o = alu_tmp[8];
      end
      5'd1: begin
        alu_tmp  = {1'b0, alu_inA} - {1'b0, alu_inB} - 9'(alu_sc_i);
        alu_rslt = alu_tmp[7:0];
        alu_sc_o = ~alu_tmp[8];
      end
      5'd2: alu_rslt = alu_inA & alu_inB;
      5'd3: alu_rslt = alu_inA ^ alu_inB;
      5'd4: alu_cnd = (alu_inA > alu_inB);
      5'd5: alu_cnd = (alu_inA == alu_inB);
      5'd6: begin
        alu_rslt = {alu_inA[6:0], alu_sc_i};
        alu_sc_o = alu_inA[7];
      end
      5'd7: begin
        alu_rslt = {alu_sc_i, alu_inA[7:1]};
        alu_sc_o = alu_inA[0];
      end
      default: ;
    endcase
  end

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic c, output logic q,
                                output int unsigned n);
    logic [W:0] wide;
    logic [W-1:0] x;
    bit mism;
    d = '0; c = 1'b0; q = 1'b0; n = NB; mism = 0;
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; d = wide[W-1:0]; c = wide[W]; end
      3'd1: begin d = a - b; c = (a >= b); end
      3'd2: d = a & b;
      3'd3: d = a ^ b;
      3'd6: begin d = a << 1; c = a[W-1]; end
      3'd7: begin d = a >> 1; c = a[0]; end
      default: begin
        x = a ^ b;
        n = 0;
        for (int k = NB - 1; k >= 0; k--) begin
          n++;
          if (x[k*8 +: 8] != 8'h00) begin mism = 1; break; end
        end
        if (op == 3'd4) begin q = (a > b); if (mism) n++; end
        else q = (a == b);
      end
    endcase
  endfunction

  // Presents one request, records the ALU command stream until rsp_valid, optionally acknowledges.
  task automatic do_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ack, output logic [W-1:0] d, output logic c, output logic q,
                        output int unsigned n);
    n = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
      if (n < 8) begin
        tr_cmd[n] = alu_cmd; tr_a[n] = alu_inA; tr_b[n] = alu_inB; tr_sc[n] = alu_sc_i;
      end
      n++;
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL rsp_timeout: op=%0d no rsp_valid after %0d cycles", op, n);
        break;
      end
    end
    d = rsp_data; c = rsp_carry; q = rsp_cnd;
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_carry, rsp_cnd} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/c/q=%b want 1000", {req_ready, rsp_valid, rsp_carry, rsp_cnd});
    end
    checks++;
    if (rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    checks++;
    if ({alu_cmd, alu_inA, alu_inB, alu_sc_i} !== '0) begin
      errors++;
      $display("FAIL reset_alu: got %h/%h/%h/%b want 0", alu_cmd, alu_inA, alu_inB, alu_sc_i);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] d; logic c, q; int unsigned n;
    do_req(3'd0, 16'h00FF, 16'h0001, 1'b1, d, c, q, n);
    checks++;
    if ({tr_cmd[0], tr_a[0], tr_b[0], tr_sc[0]} !== {5'd0, 8'hFF, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL add_lane0: got %h/%h/%h/%b want 0/ff/01/0", tr_cmd[0], tr_a[0], tr_b[0], tr_sc[0]);
    end
    checks++;
    if ({tr_cmd[1], tr_a[1], tr_b[1], tr_sc[1]} !== {5'd0, 8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL add_lane1: got %h/%h/%h/%b want 0/00/00/1", tr_cmd[1], tr_a[1], tr_b[1], tr_sc[1]);
    end
    checks++;
    if ({d, c} !== {16'h0100, 1'b0}) begin
      errors++; $display("FAIL add_result: got %h c=%b want 0100 c=0", d, c);
    end
    checks++;
    if (n + 1 !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", n + 1); end
  endtask

  task automatic test_sub();
    logic [W-1:0] d; logic c, q; int unsigned n;
    do_req(3'd1, 16'h0100, 16'h0001, 1'b1, d, c, q, n);
    checks++;
    if ({d, c} !== {16'h00FF, 1'b1}) begin
      errors++; $display("FAIL sub_noborrow: got %h c=%b want 00ff c=1", d, c);
    end
    do_req(3'd1, 16'h0000, 16'h0001, 1'b1, d, c, q, n);
    checks++;
    if ({d, c} !== {16'hFFFF, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: got %h c=%b want ffff c=0", d, c);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] d; logic c, q; int unsigned n;
    do_req(3'd7, 16'h0180, 16'h0000, 1'b1, d, c, q, n);
    checks++;
    if ({tr_cmd[0], tr_a[0]} !== {5'd7, 8'h01}) begin
      errors++; $display("FAIL lsr_order: got cmd=%h a=%h want 7/01", tr_cmd[0], tr_a[0]);
    end
    checks++;
    if ({d, c} !== {16'h00C0, 1'b0}) begin
      errors++; $display("FAIL lsr_result: got %h c=%b want 00c0 c=0", d, c);
    end
    do_req(3'd6, 16'h8080, 16'h0000, 1'b1, d, c, q, n);
    checks++;
    if ({d, c} !== {16'h0100, 1'b1}) begin
      errors++; $display("FAIL lsl_result: got %h c=%b want 0100 c=1", d, c);
    end
  endtask

  task automatic test_compare();
    logic [W-1:0] d; logic c, q; int unsigned n;
    do_req(3'd4, 16'h1234, 16'h1233, 1'b1, d, c, q, n);
    checks++;
    if (n !== 3 || {tr_cmd[0], tr_cmd[1], tr_cmd[2]} !== {5'd5, 5'd5, 5'd4} || tr_a[2] !== 8'h34) begin
      errors++;
      $display("FAIL cmp_seq: got n=%0d cmds=%0d,%0d,%0d a2=%h want 3 5,5,4 34",
               n, tr_cmd[0], tr_cmd[1], tr_cmd[2], tr_a[2]);
    end
    checks++;
    if ({q, d, c} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL cmp_gt: got q=%b d=%h c=%b want 1/0000/0", q, d, c);
    end
    do_req(3'd5, 16'h1234, 16'h5634, 1'b1, d, c, q, n);
    checks++;
    if ({n == 1, q} !== 2'b10) begin
      errors++; $display("FAIL ceq_early: got n=%0d q=%b want 1/0", n, q);
    end
    do_req(3'd4, 16'h1234, 16'h1234, 1'b1, d, c, q, n);
    checks++;
    if ({n == 2, q} !== 2'b10) begin
      errors++; $display("FAIL cmp_equal: got n=%0d q=%b want 2/0", n, q);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d, ed; logic c, q, ec, eq; int unsigned n, en; logic [2:0] op;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {a[W-1:8], 8'($urandom)};
        default: ;
      endcase
      model(op, a, b, ed, ec, eq, en);
      do_req(op, a, b, 1'b1, d, c, q, n);
      checks++;
      if ({d, c, q} !== {ed, ec, eq} || n !== en) begin
        errors++;
        $display("FAIL rand_%0d: op=%0d a=%h b=%h got d=%h c=%b q=%b n=%0d want d=%h c=%b q=%b n=%0d",
                 i, op, a, b, d, c, q, n, ed, ec, eq, en);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d, ed; logic c, q, ec, eq; int unsigned n, en;
    model(3'd1, 16'h1234, 16'h0234, ed, ec, eq, en);
    do_req(3'd1, 16'h1234, 16'h0234, 1'b0, d, c, q, n);
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'hAAAA; req_b = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_data, rsp_carry, rsp_cnd} !== {1'b1, 1'b0, ed, ec, eq}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b r=%b d=%h c=%b q=%b want 1/0/%h/%b/%b",
                 i, rsp_valid, req_ready, rsp_data, rsp_carry, rsp_cnd, ed, ec, eq);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release: got rdy=%b vld=%b want 1/0", req_ready, rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_ghost_%0d: got vld=%b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1111; req_b = 16'h2222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_carry, rsp_cnd, alu_cmd, alu_inA, alu_inB, alu_sc_i} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got vld=%b d=%h cmd=%h a=%h b=%h sc=%b want all 0",
               rsp_valid, rsp_data, alu_cmd, alu_inA, alu_inB, alu_sc_i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp_%0d: got vld=%b want 0", i, rsp_valid); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_compare();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-byte operation sequencer. It is the initiator side of the 8-bit combinational ALU.
- Accepts one NBYTES-wide request, issues one ALU command per cycle on byte lanes, chains shift/carry between lanes, collects results, and returns one response.
- Sits between the control unit and the ALU so that 16-bit (or wider) arithmetic, shifts and compares run on the existing 8-bit datapath.

Parameters:
NBYTES, 2, operand width in bytes (W = 8*NBYTES); legal range 2..4.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  3  ADD=0 SUB=1 AND=2 XOR=3 CMP=4 CEQ=5 LSL=6 LSR=7
req_a  in  W  operand A
req_b  in  W  operand B
alu_cmd  out  5  ALU command: ADD=0 SUB=1 AND=2 XOR=3 CMP=4 CEQ=5 LSL=6 LSR=7
alu_inA  out  8  current byte of A
alu_inB  out  8  current byte of B
alu_sc_i  out  1  chained shift/carry into ALU
alu_rslt  in  8  ALU byte result, same cycle
alu_sc_o  in  1  ALU carry/shift out
alu_cnd  in  1  ALU compare flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  W  assembled result (0 for CMP/CEQ)
rsp_carry  out  1  final sc_o (SUB: 1 = no borrow); 0 for AND/XOR/CMP/CEQ
rsp_cnd  out  1  CMP: A>B unsigned; CEQ: A==B; else 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rsp_valid, rsp_data, rsp_carry, rsp_cnd = 0.
  - alu_cmd, alu_inA, alu_inB, alu_sc_i = 0.
  - Latched operands cleared.
  - Reset mid-operation abandons the operation; no response is produced.
- ALU outputs are driven from registered state. The ALU is combinational, so alu_rslt/alu_sc_o/alu_cnd are captured at the edge ending each EXEC cycle. Outside EXEC the ALU outputs are 0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: req_ready=1. On req_valid, latch op/a/b, set byte index and sc register, go to EXEC.
  - EXEC: one ALU command per cycle. Last step goes to DONE with the response registered.
  - DONE: rsp_valid=1 and response held stable. On rsp_ready, go to IDLE. req_valid is ignored outside IDLE.
- Lane order and chaining:
  - ADD: low to high; first sc_i=0; next sc_i=sc_o.
  - SUB: low to high; first sc_i=0; next sc_i=~sc_o. The ALU treats sc_i as borrow-in.
  - LSL: low to high; first sc_i=0; next sc_i=sc_o (bit 7 of previous byte).
  - LSR: high to low; first sc_i=0; next sc_i=sc_o (bit 0 of previous byte).
  - AND/XOR: low to high; sc_i=0; rsp_carry=0.
  - rsp_carry = sc_o captured on the final lane.
- Compare operations, high byte first:
  - CEQ: issue CEQ per byte. cnd=0 goes to DONE with rsp_cnd=0 (early exit). cnd=1 on the lowest byte gives rsp_cnd=1.
  - CMP: issue CEQ per byte. A mismatch makes the next cycle issue CMP on the same byte; capture cnd into rsp_cnd and go to DONE. All bytes equal gives rsp_cnd=0.
  - Track the CMP issue with a phase bit.
- Latency, counted from the accept edge:
  - Arithmetic/logic/shift ops: NBYTES EXEC cycles; rsp_valid is visible NBYTES+1 cycles after accept.
  - CEQ: 1..NBYTES EXEC cycles.
  - CMP: 1..NBYTES+1 EXEC cycles.
- Throughput: at most one request per NBYTES+2 cycles. No overlap between requests.
- All arithmetic is unsigned mod 2^W; the index counter never exceeds NBYTES-1.

Decomposition:
- alu_pkg holds:
  - alu_cmd_e: 5-bit ALU command codes, including MOV=8 reserved.
  - seq_op_e: 3-bit request ops.
  - state_e.
- Optional sub-module byte_lane_mux: selects byte k of a W-bit vector and writes byte k of the result register.

Test Plan:
All cases use NBYTES=2 and a real ALU instance attached.
- ADD 0x00FF+0x0001 -> ALU sees (0,FF,01,sc_i=0) then (0,00,00,sc_i=1); rsp_data=0x0100, rsp_carry=0, rsp_valid 3 cycles after accept.
- SUB 0x0100-0x0001 -> rsp_data=0x00FF, carry=1; SUB 0x0000-0x0001 -> 0xFFFF, carry=0.
- LSR 0x0180 -> 0x00C0, carry=0, high byte issued first; LSL 0x8080 -> 0x0100, carry=1.
- CMP 0x1234 vs 0x1233 -> CEQ hi, CEQ lo, CMP lo, rsp_cnd=1; CEQ 0x1234 vs 0x5634 -> one EXEC cycle, rsp_cnd=0; CMP 0x1234 vs 0x1234 -> rsp_cnd=0.
- Backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready=0, a concurrent req_valid is not accepted; the first cycle after rsp_ready=1 returns to IDLE.
- rst_n pulsed low during the second EXEC cycle -> all outputs 0 immediately; after release req_ready=1 and no rsp_valid ever appears for the aborted request.
